// File: rtl/mon_pkg.sv
// Shared definitions for the monitor-side time-pulse blocks: pulse count,
// tracker states and the one-hot to index decode helper.
package mon_pkg;

  localparam int NUM_TP = 12;

  typedef enum logic [0:0] {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0] idx;
    logic       multi;
  } tp_dec_t;

  // Index is 1-based; multi-hot reports index 0 with the multi flag set.
  function automatic tp_dec_t onehot12_to_idx(input logic [NUM_TP-1:0] mt);
    tp_dec_t res;
    int      ones;
    res.idx   = 4'd0;
    res.multi = 1'b0;
    ones      = 0;
    for (int i = 0; i < NUM_TP; i++) begin
      if (mt[i]) begin
        ones    = ones + 1;
        res.idx = 4'(i + 1);
      end else begin
        ones    = ones;
      end
    end
    if (ones > 1) begin
      res.idx   = 4'd0;
      res.multi = 1'b1;
    end else begin
      res.multi = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/mon_timepulse_decoder_if.sv
// Monitor time-pulse bus: pulse inputs from the timing side and the decoder's
// debug/fault outputs.
interface mon_timepulse_decoder_if #(
  parameter int CNT_W = 16,
  parameter int WID_W = 8
);
  logic [11:0]      MT;
  logic             MGOJAM;
  logic             ERR_CLR;
  logic [3:0]       TP_IDX;
  logic             TP_VALID;
  logic             MCT_STB;
  logic [CNT_W-1:0] MCT_COUNT;
  logic [WID_W-1:0] LAST_WIDTH;
  logic             SEQ_ERR;
  logic             MULTI_ERR;
  logic             STALLED;
  logic             SYNCED;

  modport master (
    output MT, MGOJAM, ERR_CLR,
    input  TP_IDX, TP_VALID, MCT_STB, MCT_COUNT, LAST_WIDTH,
           SEQ_ERR, MULTI_ERR, STALLED, SYNCED
  );

  modport slave (
    input  MT, MGOJAM, ERR_CLR,
    output TP_IDX, TP_VALID, MCT_STB, MCT_COUNT, LAST_WIDTH,
           SEQ_ERR, MULTI_ERR, STALLED, SYNCED
  );
endinterface

// File: rtl/tp_onehot_dec.sv
// Combinational time-pulse decoder: one-hot MT vector to index 1..12,
// with multi-hot detection. Shared by monitor blocks.
module tp_onehot_dec
  import mon_pkg::*;
(
  input  logic [NUM_TP-1:0] mt,
  output logic [3:0]        idx,
  output logic              multi
);

  tp_dec_t dec_s;

  assign dec_s = onehot12_to_idx(mt);
  assign idx   = dec_s.idx;
  assign multi = dec_s.multi;

endmodule

// File: rtl/mon_timepulse_decoder.sv
// Receiver-side time-pulse tracker: rebuilds the pulse index, counts memory
// cycles, measures pulse widths and flags sequencing, multi-hot and stall faults.
module mon_timepulse_decoder
  import mon_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int WID_W     = 8,
  parameter int STALL_MAX = 255
) (
  input  logic                    SIM_CLK,
  input  logic                    SIM_RST,
  mon_timepulse_decoder_if.slave  bus
);

  localparam int STL_W = $clog2(STALL_MAX + 2);
  localparam logic [STL_W-1:0] STALL_TOP = STL_W'(STALL_MAX);
  localparam logic [STL_W-1:0] STALL_LIM = STL_W'(STALL_MAX + 1);
  localparam logic [WID_W-1:0] WID_MAX   = {WID_W{1'b1}};

  logic [NUM_TP-1:0] mt_q, mt_d;
  logic              gj_q, gj_d;
  state_e            state_q, state_d;
  logic [3:0]        prev_idx_q, prev_idx_d;
  logic [3:0]        tp_idx_q, tp_idx_d;
  logic              tp_valid_q, tp_valid_d;
  logic              mct_stb_q, mct_stb_d;
  logic [CNT_W-1:0]  mct_count_q, mct_count_d;
  logic [WID_W-1:0]  wid_cnt_q, wid_cnt_d;
  logic [WID_W-1:0]  last_width_q, last_width_d;
  logic [STL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              stalled_q, stalled_d;
  logic              seq_err_q, seq_err_d;
  logic              multi_err_q, multi_err_d;
  logic [3:0]        idx_s;
  logic              multi_s;

  tp_onehot_dec u_dec (
    .mt    (mt_q),
    .idx   (idx_s),
    .multi (multi_s)
  );

  // Next-state, counters and fault flags from the registered pulse sample.
  always_comb begin
    mt_d         = bus.MT;
    gj_d         = bus.MGOJAM;
    state_d      = state_q;
    prev_idx_d   = prev_idx_q;
    tp_idx_d     = idx_s;
    mct_stb_d    = 1'b0;
    mct_count_d  = mct_count_q;
    wid_cnt_d    = wid_cnt_q;
    last_width_d = last_width_q;
    stall_cnt_d  = stall_cnt_q;
    seq_err_d    = seq_err_q;
    multi_err_d  = multi_err_q;

    // Clear first so that a same-cycle error set takes priority.
    if (bus.ERR_CLR) begin
      seq_err_d   = 1'b0;
      multi_err_d = 1'b0;
    end else begin
      seq_err_d   = seq_err_q;
    end
    if (multi_s) begin
      multi_err_d = 1'b1;
    end else begin
      multi_err_d = multi_err_d;
    end

    if (gj_q) begin
      state_d     = SYNC;
      prev_idx_d  = 4'd1;
      wid_cnt_d   = '0;
      stall_cnt_d = '0;
    end else begin
      // Width only latches when a real pulse ends, not when one starts after a gap.
      if (idx_s != tp_idx_q) begin
        if (tp_idx_q != 4'd0) begin
          last_width_d = wid_cnt_q;
        end else begin
          last_width_d = last_width_q;
        end
        wid_cnt_d = (idx_s != 4'd0) ? WID_W'(1) : '0;
      end else if ((idx_s != 4'd0) && (wid_cnt_q != WID_MAX)) begin
        wid_cnt_d = wid_cnt_q + WID_W'(1);
      end else begin
        wid_cnt_d = wid_cnt_q;
      end

      if (mt_q != 12'h000) begin
        stall_cnt_d = '0;
      end else if (stall_cnt_q != STALL_LIM) begin
        stall_cnt_d = stall_cnt_q + STL_W'(1);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end

      case (state_q)
        SYNC: begin
          prev_idx_d = 4'd1;
          if (idx_s == 4'd1) begin
            state_d = TRACK;
          end else begin
            state_d = SYNC;
          end
        end
        TRACK: begin
          if ((idx_s != 4'd0) && (idx_s != prev_idx_q)) begin
            if (idx_s == prev_idx_q + 4'd1) begin
              prev_idx_d = idx_s;
            end else if ((prev_idx_q == 4'd12) && (idx_s == 4'd1)) begin
              prev_idx_d  = idx_s;
              mct_stb_d   = 1'b1;
              mct_count_d = mct_count_q + CNT_W'(1);
            end else begin
              seq_err_d  = 1'b1;
              state_d    = SYNC;
              prev_idx_d = 4'd1;
            end
          end else begin
            prev_idx_d = prev_idx_q;
          end
        end
        default: begin
          state_d    = SYNC;
          prev_idx_d = 4'd1;
        end
      endcase
    end

    tp_valid_d = (state_d == TRACK) && (idx_s != 4'd0);
    stalled_d  = (stall_cnt_d > STALL_TOP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      mt_q         <= '0;
      gj_q         <= 1'b0;
      state_q      <= SYNC;
      prev_idx_q   <= 4'd0;
      tp_idx_q     <= 4'd0;
      tp_valid_q   <= 1'b0;
      mct_stb_q    <= 1'b0;
      mct_count_q  <= '0;
      wid_cnt_q    <= '0;
      last_width_q <= '0;
      stall_cnt_q  <= '0;
      stalled_q    <= 1'b0;
      seq_err_q    <= 1'b0;
      multi_err_q  <= 1'b0;
    end else begin
      mt_q         <= mt_d;
      gj_q         <= gj_d;
      state_q      <= state_d;
      prev_idx_q   <= prev_idx_d;
      tp_idx_q     <= tp_idx_d;
      tp_valid_q   <= tp_valid_d;
      mct_stb_q    <= mct_stb_d;
      mct_count_q  <= mct_count_d;
      wid_cnt_q    <= wid_cnt_d;
      last_width_q <= last_width_d;
      stall_cnt_q  <= stall_cnt_d;
      stalled_q    <= stalled_d;
      seq_err_q    <= seq_err_d;
      multi_err_q  <= multi_err_d;
    end
  end

  assign bus.TP_IDX     = tp_idx_q;
  assign bus.TP_VALID   = tp_valid_q;
  assign bus.MCT_STB    = mct_stb_q;
  assign bus.MCT_COUNT  = mct_count_q;
  assign bus.LAST_WIDTH = last_width_q;
  assign bus.SEQ_ERR    = seq_err_q;
  assign bus.MULTI_ERR  = multi_err_q;
  assign bus.STALLED    = stalled_q;
  assign bus.SYNCED     = (state_q == TRACK);

endmodule

// File: tb/tb_mon_timepulse_decoder.sv
// Directed bench for mon_timepulse_decoder: inputs change on the falling edge,
// outputs are compared on later falling edges against hand-computed values.
module tb_mon_timepulse_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   stb_cnt  = 0;

  always #5 clk = ~clk;

  mon_timepulse_decoder_if #(.CNT_W(4), .WID_W(8)) bus ();

  mon_timepulse_decoder #(.CNT_W(4), .WID_W(8), .STALL_MAX(5)) dut (
    .SIM_CLK (clk),
    .SIM_RST (rst),
    .bus     (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n falling edges, counting MCT strobes seen along the way.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.MCT_STB === 1'b1) stb_cnt++;
    end
  endtask

  function automatic logic [11:0] onehot(input int i);
    logic [11:0] v;
    v = 12'd1 << (i - 1);
    return v;
  endfunction

  task automatic pulse(input int i, input int n);
    bus.MT = onehot(i);
    tick(n);
  endtask

  initial begin
    bus.MT = 12'd0; bus.MGOJAM = 1'b0; bus.ERR_CLR = 1'b0;
    tick(3);
    check_eq("rst_idx",    32'(bus.TP_IDX), 32'd0);
    check_eq("rst_synced", 32'(bus.SYNCED), 32'd0);
    check_eq("rst_count",  32'(bus.MCT_COUNT), 32'd0);
    check_eq("rst_seq",    32'(bus.SEQ_ERR), 32'd0);
    check_eq("rst_width",  32'(bus.LAST_WIDTH), 32'd0);
    rst = 1'b0;

    // Three clean rotations of 4-cycle pulses.
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i <= 12; i++) begin
        pulse(i, 4);
        if (r == 0 && i == 1) begin
          check_eq("sync_t01",  32'(bus.SYNCED), 32'd1);
          check_eq("idx_t01",   32'(bus.TP_IDX), 32'd1);
          check_eq("valid_t01", 32'(bus.TP_VALID), 32'd1);
          check_eq("nostb_t01", 32'(stb_cnt), 32'd0);
        end
      end
    end
    tick(2);
    check_eq("rot_count", 32'(bus.MCT_COUNT), 32'd2);
    check_eq("rot_stb",   32'(stb_cnt), 32'd2);
    check_eq("rot_width", 32'(bus.LAST_WIDTH), 32'd4);
    check_eq("rot_idx",   32'(bus.TP_IDX), 32'd12);
    check_eq("rot_seq",   32'(bus.SEQ_ERR), 32'd0);
    check_eq("rot_multi", 32'(bus.MULTI_ERR), 32'd0);

    // Gap after T12: stall threshold 5, T12 was sampled 6 times.
    bus.MT = 12'd0;
    tick(6);
    check_eq("stall_pre",   32'(bus.STALLED), 32'd0);
    check_eq("t12_width",   32'(bus.LAST_WIDTH), 32'd6);
    check_eq("gap_valid",   32'(bus.TP_VALID), 32'd0);
    check_eq("gap_synced",  32'(bus.SYNCED), 32'd1);
    tick(1);
    check_eq("stall_on",    32'(bus.STALLED), 32'd1);
    bus.MT = onehot(1);
    tick(1);
    check_eq("stall_hold",  32'(bus.STALLED), 32'd1);
    tick(1);
    check_eq("stall_off",   32'(bus.STALLED), 32'd0);
    check_eq("gap_count",   32'(bus.MCT_COUNT), 32'd3);
    check_eq("gap_stb",     32'(stb_cnt), 32'd3);

    // Out-of-order T05 -> T07.
    for (int i = 2; i <= 5; i++) pulse(i, 3);
    bus.MT = onehot(7);
    tick(1);
    check_eq("seq_lat",     32'(bus.SEQ_ERR), 32'd0);
    tick(1);
    check_eq("seq_set",     32'(bus.SEQ_ERR), 32'd1);
    check_eq("seq_unsync",  32'(bus.SYNCED), 32'd0);
    check_eq("seq_valid",   32'(bus.TP_VALID), 32'd0);
    pulse(7, 2);
    pulse(8, 3);
    bus.MT = onehot(1);
    tick(2);
    check_eq("resync",      32'(bus.SYNCED), 32'd1);
    check_eq("seq_sticky",  32'(bus.SEQ_ERR), 32'd1);
    check_eq("resync_cnt",  32'(bus.MCT_COUNT), 32'd3);
    bus.ERR_CLR = 1'b1; tick(1); bus.ERR_CLR = 1'b0; tick(1);
    check_eq("seq_clr",     32'(bus.SEQ_ERR), 32'd0);

    // Single multi-hot sample while tracking at T01.
    bus.MT = 12'h003; tick(1); bus.MT = onehot(1); tick(1);
    check_eq("multi_valid", 32'(bus.TP_VALID), 32'd0);
    check_eq("multi_idx",   32'(bus.TP_IDX), 32'd0);
    check_eq("multi_err",   32'(bus.MULTI_ERR), 32'd1);
    check_eq("multi_sync",  32'(bus.SYNCED), 32'd1);
    tick(1);
    check_eq("multi_back",  32'(bus.TP_IDX), 32'd1);
    pulse(2, 3);
    check_eq("multi_t02",   32'(bus.TP_IDX), 32'd2);
    check_eq("multi_noseq", 32'(bus.SEQ_ERR), 32'd0);
    bus.ERR_CLR = 1'b1; tick(1); bus.ERR_CLR = 1'b0; tick(1);
    check_eq("multi_clr",   32'(bus.MULTI_ERR), 32'd0);

    // GOJAM in the middle of T08 for 10 cycles, restart at T01.
    for (int i = 3; i <= 7; i++) pulse(i, 3);
    bus.MT = onehot(8);
    tick(3);
    bus.MGOJAM = 1'b1;
    tick(2);
    check_eq("gj_unsync",   32'(bus.SYNCED), 32'd0);
    tick(8);
    bus.MGOJAM = 1'b0;
    bus.MT = onehot(1);
    tick(2);
    check_eq("gj_resync",   32'(bus.SYNCED), 32'd1);
    check_eq("gj_noseq",    32'(bus.SEQ_ERR), 32'd0);
    check_eq("gj_count",    32'(bus.MCT_COUNT), 32'd3);
    check_eq("gj_nostall",  32'(bus.STALLED), 32'd0);

    // 13 more MCTs on a 4-bit counter starting at 3: 15 then wrap to 0.
    for (int k = 0; k < 13; k++) begin
      pulse(2, 1);
      if (k == 12) check_eq("wrap_15", 32'(bus.MCT_COUNT), 32'd15);
      for (int i = 3; i <= 12; i++) pulse(i, 1);
      pulse(1, 1);
    end
    tick(2);
    check_eq("wrap_0",      32'(bus.MCT_COUNT), 32'd0);
    check_eq("wrap_stb",    32'(stb_cnt), 32'd16);

    // Width saturation on a long T02.
    pulse(2, 300);
    bus.MT = onehot(3);
    tick(2);
    check_eq("width_sat",   32'(bus.LAST_WIDTH), 32'd255);
    check_eq("sat_idx",     32'(bus.TP_IDX), 32'd3);
    check_eq("sat_seq",     32'(bus.SEQ_ERR), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mon_timepulse_decoder.md
Name: mon_timepulse_decoder

Overview:
- Receiver-side companion to the timing generator. It consumes the monitor time-pulse bus (MT01..MT12, packed as MT[11:0]) and MGOJAM.
- It reconstructs the current time-pulse index, counts memory cycles (MCTs), and flags sequencing faults.
- It sits on the monitor/test side, clocked by the simulation clock. It drives debug counters and a fault register; it does not feed back into the CPU.

Parameters:
- CNT_W, 16, width of MCT_COUNT (wraps).
- WID_W, 8, width of LAST_WIDTH (saturates).
- STALL_MAX, 255, SIM_CLK cycles with no pulse asserted before STALLED is raised.

Ports:
- SIM_CLK  input  1  sole clock; all state on rising edge.
- SIM_RST  input  1  synchronous, active-high reset.
- MT  input  12  MT[n-1] = time pulse Tn, expected one-hot or all-zero.
- MGOJAM  input  1  monitor GOJAM; forces resync.
- ERR_CLR  input  1  clears sticky error flags.
- TP_IDX  output  4  index 1..12 of current pulse; 0 when none.
- TP_VALID  output  1  TRACK state and exactly one MT bit set.
- MCT_STB  output  1  one-cycle pulse per accepted T12->T01.
- MCT_COUNT  output  CNT_W  completed MCTs since reset.
- LAST_WIDTH  output  WID_W  SIM_CLK cycles the last completed pulse was high.
- SEQ_ERR  output  1  sticky: out-of-order pulse seen.
- MULTI_ERR  output  1  sticky: more than one MT bit set.
- STALLED  output  1  level: no pulse for more than STALL_MAX cycles.
- SYNCED  output  1  high in TRACK.

Behaviour:
- Clocking and reset: one clock, SIM_CLK. Reset SIM_RST is synchronous and active-high. While SIM_RST is high, all registers clear, all outputs are 0, and state is SYNC.
- Input register: MT and MGOJAM are registered once (mt_q, gj_q). All decode works on mt_q. Outputs update at the edge after mt_q changes, so latency is 2 edges from an input change.
- Decode: one-hot mt_q gives idx 1..12. All-zero gives idx 0. Multi-hot gives idx 0, TP_VALID=0, and MULTI_ERR<=1.
- States: SYNC, TRACK.
- SYNC:
  - No SEQ_ERR checking; MCT_STB never fires.
  - Go to TRACK on the first cycle mt_q==T01 one-hot with gj_q=0.
  - prev_idx<=1.
- TRACK:
  - On a new nonzero idx != prev_idx: legal only if idx==prev_idx+1, or prev_idx==12 and idx==1.
  - Legal transition: prev_idx<=idx.
  - Legal T12->T01: MCT_STB=1 for one cycle, MCT_COUNT+=1 modulo 2^CNT_W.
  - Illegal transition: SEQ_ERR<=1, state<=SYNC, no MCT_STB.
  - idx==prev_idx, or idx==0 (gap between pulses): no action.
- gj_q=1 in any state:
  - state<=SYNC; width and stall counters clear.
  - No SEQ_ERR or STALLED raised while gj_q=1.
  - MCT_COUNT is retained.
- Width counter:
  - Increments every cycle mt_q is nonzero one-hot and unchanged; saturates at 2^WID_W-1.
  - On change of idx (including to 0), the count latches into LAST_WIDTH and the counter restarts at 1 if the new idx is nonzero, else 0.
- Stall counter:
  - Counts cycles with mt_q==0 and gj_q=0; cleared by any nonzero mt_q.
  - STALLED=1 while count > STALL_MAX; clears the cycle after a pulse reappears.
  - The counter saturates at STALL_MAX+1.
- ERR_CLR: clears SEQ_ERR and MULTI_ERR. If a new error is detected in the same cycle, the set wins.
- Simultaneous events: SIM_RST > gj_q > error set > ERR_CLR. A multi-hot sample in TRACK does not change prev_idx or state.

Decomposition:
- Shared package (mon_pkg):
  - Constant NUM_TP=12.
  - State enum {SYNC, TRACK}.
  - Function onehot12_to_idx (returns 4-bit idx plus multi flag).
- Sub-module tp_onehot_dec (combinational one-hot-to-index with multi-hot detect). Reusable by other monitor blocks.

Test Plan:
- Reset, then drive T01..T12 each 4 cycles high, repeated 3 times -> SYNCED=1 after the first T01, MCT_STB exactly twice, MCT_COUNT=2, LAST_WIDTH=4, no errors.
- In TRACK at T05, drive T07 -> SEQ_ERR=1 two edges later, SYNCED=0; the next T01 resyncs; ERR_CLR=1 for one cycle -> SEQ_ERR=0.
- Drive MT=12'h003 for one cycle -> MULTI_ERR=1, TP_VALID=0, TP_IDX=0, state unchanged.
- Assert MGOJAM mid-T08 for 10 cycles, then start at T01 -> no SEQ_ERR, SYNCED returns on T01, MCT_COUNT unchanged.
- With STALL_MAX=5, hold MT=0 for 7 cycles -> STALLED=1 from the 6th counted cycle; T01 reappears -> STALLED=0.
- Preload MCT_COUNT with CNT_W=4 and run 16 MCTs -> count wraps to 0. Hold one pulse for 300 cycles -> LAST_WIDTH=255.
